// File: rtl/ic1_fill_if.sv
// ----------------------------------------------------------------------------
// ic1_fill_if
//
// Bundle of every handshake and bus signal around the L1 I-cache line-fill
// sequencer: the fetch miss channel, the memory request/response channels,
// the I-cache array write port and the completion pulses.
//
// Modports:
//   master : the fill sequencer (drives miss_ready, mem_req_*, ic_*, fill_*)
//   slave  : the environment (fetch, memory and the I-cache arrays)
//
// Handshake rules:
//   miss channel    : a miss transfers on a rising edge where miss_valid and
//                     miss_ready are both 1.
//   mem_req channel : mem_req_valid is held with mem_req_paddr stable until a
//                     rising edge where mem_req_ready is 1; that edge is the
//                     single transfer.
//   mem_rsp channel : no backpressure; every edge with mem_rsp_valid=1 is one
//                     beat.
//
// The optional fetch-bypass signals exist only when IC1_FILL_BYPASS_EN is
// defined.
// ----------------------------------------------------------------------------
interface ic1_fill_if #(
    parameter int NPHYS = 55
);
    logic                flush;
    logic                miss_valid;
    logic                miss_ready;
    logic [NPHYS-7:0]    miss_paddr;
    logic                mem_req_valid;
    logic                mem_req_ready;
    logic [NPHYS-7:0]    mem_req_paddr;
    logic                mem_rsp_valid;
    logic [63:0]         mem_rsp_data;
    logic                mem_rsp_last;
    logic                mem_rsp_err;
    logic                ic_wen;
    logic [5:0]          ic_waddr;
    logic [511:0]        ic_din;
    logic [NPHYS-13:0]   ic_tin;
    logic                fill_done;
    logic                fill_err;
`ifdef IC1_FILL_BYPASS_EN
    logic                byp_valid;
    logic [2:0]          byp_beat;
    logic [63:0]         byp_data;
    logic [NPHYS-7:0]    byp_paddr;
`endif

    modport master (
        input  flush, miss_valid, miss_paddr, mem_req_ready,
               mem_rsp_valid, mem_rsp_data, mem_rsp_last, mem_rsp_err,
        output miss_ready, mem_req_valid, mem_req_paddr,
               ic_wen, ic_waddr, ic_din, ic_tin, fill_done, fill_err
`ifdef IC1_FILL_BYPASS_EN
        , output byp_valid, byp_beat, byp_data, byp_paddr
`endif
    );

    modport slave (
        output flush, miss_valid, miss_paddr, mem_req_ready,
               mem_rsp_valid, mem_rsp_data, mem_rsp_last, mem_rsp_err,
        input  miss_ready, mem_req_valid, mem_req_paddr,
               ic_wen, ic_waddr, ic_din, ic_tin, fill_done, fill_err
`ifdef IC1_FILL_BYPASS_EN
        , input byp_valid, byp_beat, byp_data, byp_paddr
`endif
    );
endinterface

// File: rtl/ic1_fill.sv
// ----------------------------------------------------------------------------
// ic1_fill
//
// L1 instruction-cache line-fill sequencer. Takes one fetch miss at a time,
// issues a single line request to memory, assembles eight 64-bit beats into
// a 512-bit line and writes line + physical tag into the I-cache arrays in a
// single cycle. Flush aborts a fill at any point; bus errors and malformed
// bursts terminate the fill with a fill_err pulse and no array write.
//
// Ports:
//   clk        : rising-edge clock
//   reset_n    : asynchronous active-low reset
//   bus        : ic1_fill_if.master (miss, mem_req, mem_rsp, ic write,
//                fill_done / fill_err, optional bypass)
//   dbg_state  : current FSM state (IDLE=0, REQ=1, BEAT=2, WRITE=3, DRAIN=4)
//
// Parameters:
//   NPHYS  : physical address width (tag = [NPHYS-1:12], index = [11:6])
//   NBEATS : beats per line, fixed at 8
//
// Optional feature macro: IC1_FILL_BYPASS_EN
//   When defined, every clean beat accepted in BEAT is forwarded on byp_*
//   in the same cycle so fetch can start before the line is written.
// ----------------------------------------------------------------------------
module ic1_fill #(
    parameter int NPHYS  = 55,
    parameter int NBEATS = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    ic1_fill_if.master    bus,
    output logic [2:0]    dbg_state
);

    localparam logic [2:0] LAST_BEAT = 3'(NBEATS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_BEAT  = 3'd2,
        S_WRITE = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [NPHYS-7:0]     paddr_q, paddr_d;
    logic [2:0]           cnt_q,   cnt_d;
    // err_q: the burst in flight is already doomed (bus error seen, or the
    // burst overran into DRAIN). In DRAIN it decides whether the final
    // beat raises fill_err.
    logic                 err_q,   err_d;
    logic [511:0]         line_q,  line_d;
    logic                 fill_err_q, fill_err_d;

    logic                 beat_err;
    logic                 rsp_beat;
    logic                 rsp_end;

    assign rsp_beat = bus.mem_rsp_valid;
    assign rsp_end  = bus.mem_rsp_valid && bus.mem_rsp_last;
    assign beat_err = err_q || bus.mem_rsp_err;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            paddr_q    <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            line_q     <= '0;
            fill_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            paddr_q    <= paddr_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            line_q     <= line_d;
            fill_err_q <= fill_err_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        paddr_d    = paddr_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        line_d     = line_q;
        fill_err_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                // flush outranks a simultaneous miss
                if (bus.miss_valid && !bus.flush) begin
                    paddr_d = bus.miss_paddr;
                    state_d = S_REQ;
                end
            end

            S_REQ: begin
                if (bus.mem_req_ready) begin
                    cnt_d = '0;
                    err_d = 1'b0;
                    // once memory has taken the request its burst must be
                    // consumed, even when the fill is being abandoned
                    state_d = bus.flush ? S_DRAIN : S_BEAT;
                end else if (bus.flush) begin
                    state_d = S_IDLE;
                end
            end

            S_BEAT: begin
                if (bus.flush) begin
                    // abandoned fill: drain quietly, or stop now if this
                    // very beat is the end of the burst
                    err_d   = 1'b0;
                    state_d = rsp_end ? S_IDLE : S_DRAIN;
                end else if (rsp_beat) begin
                    line_d[{cnt_q, 6'b0} +: 64] = bus.mem_rsp_data;
                    cnt_d = cnt_q + 3'd1;
                    err_d = beat_err;
                    if (bus.mem_rsp_last) begin
                        if (cnt_q == LAST_BEAT && !beat_err) begin
                            state_d = S_WRITE;
                        end else begin
                            // bus error or early last: no write
                            fill_err_d = 1'b1;
                            state_d    = S_IDLE;
                        end
                    end else if (cnt_q == LAST_BEAT) begin
                        // burst is longer than a line; swallow the rest
                        err_d   = 1'b1;
                        state_d = S_DRAIN;
                    end
                end
            end

            S_WRITE: begin
                state_d = S_IDLE;
            end

            S_DRAIN: begin
                if (bus.flush) begin
                    err_d = 1'b0;
                end
                if (rsp_end) begin
                    fill_err_d = err_q && !bus.flush;
                    state_d    = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.miss_ready    = (state_q == S_IDLE);
    assign bus.mem_req_valid = (state_q == S_REQ);
    assign bus.mem_req_paddr = paddr_q;

    // A flush arriving in the write cycle still cancels the array write.
    assign bus.ic_wen        = (state_q == S_WRITE) && !bus.flush;
    assign bus.fill_done     = (state_q == S_WRITE) && !bus.flush;
    assign bus.ic_waddr      = paddr_q[5:0];
    assign bus.ic_tin        = paddr_q[NPHYS-7:6];
    assign bus.ic_din        = line_q;
    assign bus.fill_err      = fill_err_q;

    assign dbg_state         = state_q;

`ifdef IC1_FILL_BYPASS_EN
    assign bus.byp_valid = (state_q == S_BEAT) && bus.mem_rsp_valid &&
                           !bus.mem_rsp_err && !bus.flush;
    assign bus.byp_beat  = cnt_q;
    assign bus.byp_data  = bus.mem_rsp_data;
    assign bus.byp_paddr = paddr_q;
`endif

endmodule

// File: doc/ic1_fill.md
Name: ic1_fill

Overview:
- L1 instruction-cache line-fill sequencer, directly upstream of the L1 I-cache data/tag RAM write port.
- Accepts one miss at a time from fetch and issues a line request to the memory side.
- Assembles eight 64-bit response beats into a 512-bit line, then performs a single-cycle write of line data and physical tag into the I-cache arrays.
- Handles flush and abort, bus error and malformed bursts.

Parameters:
NPHYS, 55, physical address width; tag is bits [NPHYS-1:12], set index is bits [11:6]
NBEATS, 8, beats per line; fixed at 8 (64-bit beats x 8 = 512 bits); other values are illegal

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
flush  in  1  abort any fill in progress (fence.i, redirect)
miss_valid  in  1  fetch miss request
miss_ready  out  1  block idle, can accept a miss
miss_paddr  in  NPHYS-6  line physical address [NPHYS-1:6]
mem_req_valid  out  1  line read request to memory
mem_req_ready  in  1  memory accepts request
mem_req_paddr  out  NPHYS-6  registered line address
mem_rsp_valid  in  1  response beat valid (no backpressure)
mem_rsp_data  in  64  beat data, beat 0 first
mem_rsp_last  in  1  final beat of burst
mem_rsp_err  in  1  bus error on this beat
ic_wen  out  1  I-cache array write enable
ic_waddr  out  6  set index = paddr[11:6]
ic_din  out  512  assembled line; beat k occupies [64k+63:64k]
ic_tin  out  NPHYS-12  tag = paddr[NPHYS-1:12]
fill_done  out  1  one-cycle pulse; line written
fill_err  out  1  one-cycle pulse; fill terminated without write

Behaviour:
- Reset values: state IDLE, beat counter 0, err flag 0, all outputs 0 except miss_ready=1. ic_din/ic_tin/ic_waddr reset to 0.
- Reset may be asserted mid-operation; the block returns to IDLE immediately and no write occurs.
- States: IDLE, REQ, BEAT, WRITE, DRAIN.
- IDLE:
  - miss_ready=1.
  - On miss_valid&&!flush, latch miss_paddr and go to REQ.
  - mem_req_valid rises the next cycle.
- REQ:
  - mem_req_valid=1 with paddr held stable until mem_req_ready.
  - On the handshake, go to BEAT with counter=0.
  - flush in REQ with mem_req_ready=0: go to IDLE, no fill_err.
  - flush in REQ with mem_req_ready=1: the request is taken, so go to DRAIN.
- BEAT:
  - Each mem_rsp_valid writes mem_rsp_data into line slot [counter], sets err flag if mem_rsp_err, and increments counter (3 bits).
  - A beat with last=1 and counter==7 that is error-free (err flag and this beat's error both clear) goes to WRITE.
  - last=1 with counter!=7, or counter==7 with last=0, is a malformed burst: set err.
  - Any error-terminated burst pulses fill_err the cycle after its last beat and returns to IDLE.
  - After counter==7 with last=0, go to DRAIN.
- WRITE:
  - ic_wen=1 and fill_done=1 for exactly one cycle, the cycle after the last beat; ic_waddr, ic_tin and ic_din are valid that cycle.
  - Then return to IDLE; miss_ready=1 on the following cycle.
  - Latency from last beat to ic_wen is 1 cycle.
- DRAIN:
  - Consume beats with no data capture until a beat with mem_rsp_last, then go to IDLE.
  - fill_err pulses when DRAIN was entered due to a malformed burst; there is no pulse for flush.
- flush in BEAT: go to DRAIN, or directly to IDLE if the same cycle carries mem_rsp_last.
- flush in WRITE: ic_wen and fill_done are suppressed; return to IDLE.
- flush takes priority over miss_valid in IDLE.
- ic_wen is never asserted outside WRITE.
- miss_ready=0 in every state but IDLE.

Optional Feature:
IC1_FILL_BYPASS_EN
- Defined: adds outputs byp_valid(1), byp_beat(3), byp_data(64), byp_paddr(NPHYS-6).
  - Each beat accepted in BEAT with mem_rsp_err=0 and flush=0 is forwarded combinationally in the same cycle, so fetch can consume instructions before the line write.
  - byp_valid is 0 in DRAIN.
- Undefined: ports absent; fetch waits for fill_done.

Test Plan:
- Reset released, miss paddr=0x123_4567_89C0 (index 0x27), mem_req_ready tied 1, 8 beats data=beat index replicated -> one ic_wen pulse the cycle after beat 7, ic_waddr=0x27, ic_tin=paddr[54:12], ic_din[64k+63:64k]=k, fill_done=1 once.
- mem_req_ready held 0 for 5 cycles -> mem_req_valid and mem_req_paddr stable 5 cycles, miss_ready=0 throughout, one request handshake only.
- mem_rsp_err=1 on beat 3 of 8 -> no ic_wen, fill_err pulse the cycle after beat 7, miss_ready=1 on the next cycle.
- mem_rsp_last on beat 5 -> fill_err pulse, no write; separately, 9-beat burst -> DRAIN consumes beat 8, fill_err, no write.
- flush during beat 4 -> remaining beats drained, no ic_wen, no fill_err; flush in the WRITE cycle -> ic_wen stays 0; flush with miss_valid in IDLE -> no request issued.
- reset_n low during beat 2 -> outputs at reset values asynchronously; after release, a new miss completes normally with correct data.
